otter_mem_arbiter: RTL and testbench
====================================

# otter_mem_arbiter

Two-requester arbiter that shares one single-port, handshaked memory bus between the OTTER MCU instruction-fetch port and its data port. It sits between `otter_mcu` (imem/dmem sides) and a unified memory or bus bridge. It registers each granted request, tracks the outstanding transaction, applies a bounded data-priority policy with anti-starvation for fetches, and returns read data and completion pulses to the owning requester. A timeout converts a missing acknowledge into an error completion.

## Interface
- `BURST_LIMIT`, default 4: max consecutive dmem grants while imem is pending before imem is forced a grant.
- `TIMEOUT_CYCLES`, default 16: cycles in BUSY without `i_mem_ack` before error completion; legal range 1..255.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_imem_req`  in  1  fetch request; held until `o_imem_valid`.
- `i_imem_addr`  in  32  fetch byte address.
- `o_imem_r_data`  out  32  fetch data; valid only with `o_imem_valid`.
- `o_imem_valid`  out  1  one-cycle fetch completion pulse.
- `i_dmem_re`, `i_dmem_we`  in  1 each  data read or write request; held until `o_dmem_valid`; both high is treated as a write.
- `i_dmem_sel`  in  4  byte enables.
- `i_dmem_addr`, `i_dmem_w_data`  in  32 each  data address and write data.
- `o_dmem_r_data`  out  32  read data; valid only with `o_dmem_valid`.
- `o_dmem_valid`  out  1  one-cycle data completion pulse, for reads and writes.
- `o_err`  out  1  high together with a valid pulse when that completion timed out.
- `o_mem_req`  out  1  bus request; held high until ack or timeout.
- `o_mem_we`  out  1  write strobe.
- `o_mem_sel`  out  4  byte enables; 4'b1111 for fetches.
- `o_mem_addr`, `o_mem_w_data`  out  32 each  registered address and write data.
- `i_mem_ack`  in  1  completion from memory; ignored unless `o_mem_req` is high.
- `i_mem_r_data`  in  32  read data; sampled in the `i_mem_ack` cycle.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: sample requests. dmem pending (`re|we`) wins unless imem is pending and `burst_cnt == BURST_LIMIT`. On a grant, register owner, addr, sel, we and w_data. Go to BUSY. With no request, stay in IDLE.
- Fetch grant: `o_mem_we=0`, `o_mem_sel=4'b1111`, `o_mem_w_data=0`.
- burst_cnt, 0..BURST_LIMIT:
  - increments on a dmem grant while imem is pending;
  - clears on any imem grant;
  - clears on a dmem grant with imem idle;
  - saturates at BURST_LIMIT.
- BUSY: `o_mem_req=1`; bus outputs stable. The timeout counter starts at 0 on entry and increments each cycle without ack.
  - On `i_mem_ack`: latch `i_mem_r_data` (0 for writes), clear err, go to RESP.
  - If the counter reaches `TIMEOUT_CYCLES-1` without ack: latch data 0, set err, go to RESP. `o_mem_req` drops in RESP.
  - Ack and the timeout in the same cycle: ack wins, err=0.
- RESP: one cycle. Pulse the owner's valid, drive `o_*_r_data` from the latch, drive `o_err=err`. Return to IDLE. The requester may drop or change its request in the cycle after the valid pulse.
- Non-owner valid is always 0. `o_imem_valid` and `o_dmem_valid` are never high together.
- A requester that drops its request during BUSY does not abort the transaction. Completion is still pulsed and may be ignored.

## Timing
- Reset (synchronous): state=IDLE, counters 0. All outputs are 0 from the first cycle after the reset edge, including `o_mem_req`, valids, `o_err`, data and address. An in-flight transaction is abandoned and a late `i_mem_ack` is ignored.
- Request seen in IDLE at edge N. `o_mem_req` is high from N+1. Ack at edge N+1+k. Valid pulse during cycle N+2+k. Minimum request-to-valid latency is 3 cycles (ack with zero wait states).
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, BUSY, RESP).
- Timeout: `o_mem_req` is high for exactly `TIMEOUT_CYCLES` cycles, then a valid pulse with `o_err=1`.
- Data outputs hold the last latched value outside RESP. Benches check them only with valid.

## Test plan
- Single fetch: imem addr 0x100, ack 1 cycle after req with data 0x82f7b013. Required: `o_mem_addr=0x100`, sel=F, we=0; `o_imem_valid` for 1 cycle with data 0x82f7b013; `o_err=0`.
- Data write: addr 0x2000, sel 4'b0011, data 0xA5A5_1234, ack after 3 wait cycles. Required: `o_mem_we=1` and bus fields stable for 4 cycles; `o_dmem_valid` pulse; imem gets no pulse.
- Contention: imem and dmem held continuously, zero-wait ack, `BURST_LIMIT=4`. Required grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: dmem read, no ack, `TIMEOUT_CYCLES=16`. Required: `o_mem_req` high for exactly 16 cycles; `o_dmem_valid=1`, `o_err=1`, data 0. The next request then completes normally with err=0.
- Reset mid-BUSY: assert `i_rst` during cycle 2 of a fetch and fire ack in the same cycle. Required: all outputs 0 next cycle, no valid pulse, state IDLE.
- Ack and timeout coincident (ack in the last timeout cycle): valid with err=0 and the acked data.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// Shares one handshaked memory bus between the OTTER fetch and data ports.
// Data has priority, but a waiting fetch is forced through after BURST_LIMIT data grants.
module otter_mem_arbiter #(
   parameter int unsigned BURST_LIMIT    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   // instruction fetch port
   input  logic        i_imem_req,
   input  logic [31:0] i_imem_addr,
   output logic [31:0] o_imem_r_data,
   output logic        o_imem_valid,
   // data port
   input  logic        i_dmem_re,
   input  logic        i_dmem_we,
   input  logic [3:0]  i_dmem_sel,
   input  logic [31:0] i_dmem_addr,
   input  logic [31:0] i_dmem_w_data,
   output logic [31:0] o_dmem_r_data,
   output logic        o_dmem_valid,
   output logic        o_err,
   // shared memory bus
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_sel,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_w_data,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_r_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned BW = (BURST_LIMIT < 1) ? 1 : $clog2(BURST_LIMIT + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LIMIT);
   localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]    r_state;
   logic          r_owner_d;   // 1: data port owns the transaction
   logic [31:0]   r_addr;
   logic [3:0]    r_sel;
   logic          r_we;
   logic [31:0]   r_w_data;
   logic [31:0]   r_r_data;
   logic          r_err;
   logic [BW-1:0] r_burst;
   logic [7:0]    r_to_cnt;

   logic w_imem_pend;
   logic w_dmem_pend;
   logic w_grant_d;
   logic w_grant_i;
   logic w_timeout;

   assign w_imem_pend = i_imem_req;
   assign w_dmem_pend = i_dmem_re | i_dmem_we;
   assign w_grant_d   = w_dmem_pend && !(w_imem_pend && (r_burst == BURST_MAX));
   assign w_grant_i   = w_imem_pend && !w_grant_d;
   assign w_timeout   = (r_to_cnt == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_owner_d <= 1'b0;
         r_addr    <= '0;
         r_sel     <= '0;
         r_we      <= 1'b0;
         r_w_data  <= '0;
         r_r_data  <= '0;
         r_err     <= 1'b0;
         r_burst   <= '0;
         r_to_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_to_cnt <= '0;
               if (w_grant_d) begin
                  r_owner_d <= 1'b1;
                  r_addr    <= i_dmem_addr;
                  r_sel     <= i_dmem_sel;
                  r_we      <= i_dmem_we;
                  r_w_data  <= i_dmem_w_data;
                  r_state   <= ST_BUSY;
                  if (!w_imem_pend) begin
                     r_burst <= '0;
                  end else if (r_burst != BURST_MAX) begin
                     r_burst <= r_burst + BW'(1);
                  end
               end else if (w_grant_i) begin
                  r_owner_d <= 1'b0;
                  r_addr    <= i_imem_addr;
                  r_sel     <= 4'b1111;
                  r_we      <= 1'b0;
                  r_w_data  <= '0;
                  r_burst   <= '0;
                  r_state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // ack takes precedence over a timeout landing in the same cycle
               if (i_mem_ack) begin
                  r_r_data <= r_we ? 32'h0 : i_mem_r_data;
                  r_err    <= 1'b0;
                  r_state  <= ST_RESP;
               end else if (w_timeout) begin
                  r_r_data <= '0;
                  r_err    <= 1'b1;
                  r_state  <= ST_RESP;
               end else begin
                  r_to_cnt <= r_to_cnt + 8'd1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_mem_req     = (r_state == ST_BUSY);
   assign o_mem_we      = r_we;
   assign o_mem_sel     = r_sel;
   assign o_mem_addr    = r_addr;
   assign o_mem_w_data  = r_w_data;

   assign o_imem_valid  = (r_state == ST_RESP) && !r_owner_d;
   assign o_dmem_valid  = (r_state == ST_RESP) && r_owner_d;
   assign o_err         = (r_state == ST_RESP) && r_err;
   assign o_imem_r_data = r_r_data;
   assign o_dmem_r_data = r_r_data;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter (BURST_LIMIT=4, TIMEOUT_CYCLES=16).
module tb_otter_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [31:0] imem_r_data;
   logic        imem_valid;
   logic        dmem_re = 1'b0;
   logic        dmem_we = 1'b0;
   logic [3:0]  dmem_sel = '0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_w_data = '0;
   logic [31:0] dmem_r_data;
   logic        dmem_valid;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_w_data;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_r_data = '0;

   int n_checks = 0;
   int n_errors = 0;

   otter_mem_arbiter #(
      .BURST_LIMIT    (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_imem_req    (imem_req),
      .i_imem_addr   (imem_addr),
      .o_imem_r_data (imem_r_data),
      .o_imem_valid  (imem_valid),
      .i_dmem_re     (dmem_re),
      .i_dmem_we     (dmem_we),
      .i_dmem_sel    (dmem_sel),
      .i_dmem_addr   (dmem_addr),
      .i_dmem_w_data (dmem_w_data),
      .o_dmem_r_data (dmem_r_data),
      .o_dmem_valid  (dmem_valid),
      .o_err         (err),
      .o_mem_req     (mem_req),
      .o_mem_we      (mem_we),
      .o_mem_sel     (mem_sel),
      .o_mem_addr    (mem_addr),
      .o_mem_w_data  (mem_w_data),
      .i_mem_ack     (mem_ack),
      .i_mem_r_data  (mem_r_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_sel, mem_addr, imem_valid, dmem_valid, err} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {mem_req, mem_we, mem_sel, mem_addr, imem_valid, dmem_valid, err});
      end
      rst = 1'b0;
      mem_ack = 1'b1;  // stray ack while idle
      tick();
      n_checks++;
      if ({mem_req, imem_valid, dmem_valid} !== 3'b000) begin
         n_errors++;
         $display("FAIL idle_ack_ignored: got %b want 000", {mem_req, imem_valid, dmem_valid});
      end
      mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_single_fetch();
      imem_req  = 1'b1;
      imem_addr = 32'h100;
      tick();
      n_checks++;
      if ({mem_req, mem_we, mem_sel, mem_addr, mem_w_data} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0})
      begin
         n_errors++;
         $display("FAIL fetch_bus: got req=%b we=%b sel=%h addr=%h wd=%h want 1 0 f 00000100 0",
                  mem_req, mem_we, mem_sel, mem_addr, mem_w_data);
      end
      mem_ack    = 1'b1;
      mem_r_data = 32'h82f7b013;
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({imem_valid, dmem_valid, err, mem_req} !== 4'b1000) begin
         n_errors++;
         $display("FAIL fetch_valid: got iv,dv,err,req=%b want 1000",
                  {imem_valid, dmem_valid, err, mem_req});
      end
      n_checks++;
      if (imem_r_data !== 32'h82f7b013) begin
         n_errors++;
         $display("FAIL fetch_data: got %h want 82f7b013", imem_r_data);
      end
      tick();
      n_checks++;
      if (imem_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL fetch_pulse_width: got %b want 0", imem_valid);
      end
      imem_req = 1'b0;
   endtask

   task automatic test_data_write();
      dmem_we     = 1'b1;
      dmem_sel    = 4'b0011;
      dmem_addr   = 32'h2000;
      dmem_w_data = 32'hA5A5_1234;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({mem_req, mem_we, mem_sel, mem_addr, mem_w_data}
             !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hA5A5_1234}) begin
            n_errors++;
            $display("FAIL write_bus[%0d]: got req=%b we=%b sel=%h addr=%h wd=%h want 1 1 3 2000 a5a51234",
                     i, mem_req, mem_we, mem_sel, mem_addr, mem_w_data);
         end
         if (i == 3) begin
            mem_ack    = 1'b1;
            mem_r_data = 32'hFFFF_FFFF;
         end
         tick();
      end
      mem_ack = 1'b0;
      n_checks++;
      if ({dmem_valid, imem_valid, err, mem_req} !== 4'b1000) begin
         n_errors++;
         $display("FAIL write_valid: got dv,iv,err,req=%b want 1000",
                  {dmem_valid, imem_valid, err, mem_req});
      end
      n_checks++;
      if (dmem_r_data !== 32'h0) begin
         n_errors++;
         $display("FAIL write_rdata: got %h want 0", dmem_r_data);
      end
      tick();
      dmem_we = 1'b0;
   endtask

   task automatic test_contention();
      logic exp_d;
      imem_req  = 1'b1;
      imem_addr = 32'h400;
      dmem_re   = 1'b1;
      dmem_sel  = 4'hF;
      dmem_addr = 32'h3000;
      for (int i = 0; i < 10; i++) begin
         exp_d = ((i % 5) != 4);  // D,D,D,D,I repeating
         tick();
         n_checks++;
         if (mem_addr !== (exp_d ? 32'h3000 : 32'h400)) begin
            n_errors++;
            $display("FAIL cont_grant[%0d]: got addr %h want %h",
                     i, mem_addr, exp_d ? 32'h3000 : 32'h400);
         end
         mem_ack    = 1'b1;
         mem_r_data = 32'h1000 + 32'(i);
         tick();
         mem_ack = 1'b0;
         n_checks++;
         if ({imem_valid, dmem_valid} !== (exp_d ? 2'b01 : 2'b10)) begin
            n_errors++;
            $display("FAIL cont_valid[%0d]: got iv,dv=%b want %b",
                     i, {imem_valid, dmem_valid}, exp_d ? 2'b01 : 2'b10);
         end
         tick();
      end
      imem_req = 1'b0;
      dmem_re  = 1'b0;
   endtask

   task automatic test_timeout();
      int cnt;
      dmem_re   = 1'b1;
      dmem_sel  = 4'hF;
      dmem_addr = 32'h3004;
      tick();
      cnt = 0;
      while (mem_req === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 16) begin
         n_errors++;
         $display("FAIL timeout_req_cycles: got %0d want 16", cnt);
      end
      n_checks++;
      if ({dmem_valid, imem_valid, err, dmem_r_data} !== {3'b101, 32'h0}) begin
         n_errors++;
         $display("FAIL timeout_completion: got dv=%b iv=%b err=%b data=%h want 1 0 1 0",
                  dmem_valid, imem_valid, err, dmem_r_data);
      end
      tick();
      dmem_re = 1'b0;
      tick();
      // follow-up request completes normally
      dmem_re   = 1'b1;
      dmem_addr = 32'h3008;
      tick();
      mem_ack    = 1'b1;
      mem_r_data = 32'h1122_3344;
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({dmem_valid, err, dmem_r_data} !== {2'b10, 32'h1122_3344}) begin
         n_errors++;
         $display("FAIL after_timeout: got dv=%b err=%b data=%h want 1 0 11223344",
                  dmem_valid, err, dmem_r_data);
      end
      tick();
      dmem_re = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      logic [136:0] outs;
      int           stray;
      imem_req  = 1'b1;
      imem_addr = 32'h500;
      tick();
      tick();
      rst        = 1'b1;
      mem_ack    = 1'b1;
      mem_r_data = 32'hDEAD_BEEF;
      tick();
      outs = {mem_req, mem_we, mem_sel, mem_addr, mem_w_data, imem_valid, dmem_valid, err,
              imem_r_data, dmem_r_data};
      n_checks++;
      if (outs !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_busy_outs: got %h want 0", outs);
      end
      rst      = 1'b0;
      mem_ack  = 1'b0;
      imem_req = 1'b0;
      stray    = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_req || imem_valid || dmem_valid) stray++;
      end
      n_checks++;
      if (stray != 0) begin
         n_errors++;
         $display("FAIL reset_mid_busy_idle: got %0d active cycles want 0", stray);
      end
   endtask

   task automatic test_ack_timeout_coincident();
      int dropped;
      dmem_re   = 1'b1;
      dmem_sel  = 4'hF;
      dmem_addr = 32'h3010;
      tick();
      dropped = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (mem_req !== 1'b1) dropped++;
      end
      n_checks++;
      if (dropped != 0) begin
         n_errors++;
         $display("FAIL coincident_req_held: got %0d low cycles want 0", dropped);
      end
      mem_ack    = 1'b1;
      mem_r_data = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      n_checks++;
      if ({dmem_valid, err, dmem_r_data} !== {2'b10, 32'hCAFE_F00D}) begin
         n_errors++;
         $display("FAIL coincident_completion: got dv=%b err=%b data=%h want 1 0 cafef00d",
                  dmem_valid, err, dmem_r_data);
      end
      tick();
      dmem_re = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_data_write();
      test_contention();
      test_timeout();
      test_reset_mid_busy();
      test_ack_timeout_coincident();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
